serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
- Multi-cycle N-bit add/subtract unit for the MIPS datapath.
- Sequences one instance of the existing 1-bit full-adder cell `adder` over the operands, one bit per clock, LSB first.
- Intended as a low-area ALU add path and as the serial arithmetic engine for multi-cycle instructions.
- Uses a start/done handshake toward the control unit; results hold until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- abort  input  1  synchronous cancel of a running operation.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy, done, result, carry_out, overflow and counter all clear to 0.
  - zero resets to 1, consistent with result = 0.
  - Reset mid-RUN discards the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a_in into the A shift register.
  - Latch b_in XOR {WIDTH{sub}} into the B shift register.
  - Set carry register = sub and counter = 0, then go to RUN.
- RUN, each cycle:
  - The adder cell receives A[0], B[0] and the carry register.
  - Sum is shifted into the result shift register at the MSB (right shift); A and B shift right.
  - The carry register takes CarryOut; counter increments.
  - When counter == WIDTH−1, the carry register's value before the update is saved as c_msb_in, and the state goes to DONE.
- DONE (exactly 1 cycle):
  - done=1.
  - carry_out = final carry.
  - overflow = c_msb_in XOR final carry.
  - zero = (result == 0).
  - Next state is IDLE.
- Latency:
  - start sampled at edge k.
  - busy is high for edges k+1 .. k+WIDTH.
  - done is high in the cycle after edge k+WIDTH+1.
  - Next start is accepted at edge k+WIDTH+2 at the earliest.
- start while busy or in DONE: ignored; no queuing.
- abort in RUN: go to IDLE next edge; no done. result, carry_out, overflow and zero keep their values from the previous completed operation; internal shift registers are discarded.
- abort in IDLE or DONE: no effect; DONE still returns to IDLE.
- abort and start together in IDLE: start wins.
- Outputs are registered and stable between done pulses. result is only updated visibly at completion; the internal shift register is separate from the output register.
- Arithmetic is modulo 2^WIDTH. sub with b_in = 0 gives carry_out=1.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - op encoding: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module instance: the existing `adder` cell (ports a, b, CarryIn, Sum, CarryOut), instance name u_bit_adder. No other hierarchy.

Test Plan (WIDTH=8 bench plus one WIDTH=32 regression):
- Reset then idle → result=0, zero=1, done=0, busy=0; reset released mid-cycle causes no spurious done.
- start, sub=0, A=8'h3C, B=8'h05 → busy for 8 cycles; done on cycle 9 after start; result=8'h41, carry_out=0, overflow=0, zero=0.
- start, sub=0, A=8'h7F, B=8'h01 → result=8'h80, overflow=1, carry_out=0; then A=8'hFF, B=8'h01 → result=8'h00, carry_out=1, overflow=0, zero=1.
- start, sub=1, A=8'h05, B=8'h07 → result=8'hFE, carry_out=0 (borrow); A=8'h80, B=8'h01 → result=8'h7F, overflow=1.
- start pulsed during RUN and in DONE cycle → ignored; single done, result matches the first operands. Back-to-back start at the earliest legal edge gives correct second result.
- abort at RUN cycle 3 of A=8'h10, B=8'h20 → no done; result still holds the previous 8'h41. rst_n asserted mid-RUN → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/serial_add_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_sequencer_pkg : shared state and op encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_add_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder : 1-bit full-adder cell
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder (
  input  logic a,
  input  logic b,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);

  assign Sum      = a ^ b ^ CarryIn;
  assign CarryOut = (a & b) | (a & CarryIn) | (b & CarryIn);

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ----------------------------------------------------------------------------
// serial_add_sequencer : bit-serial add/sub, one full-adder cell, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sh;
  logic               r_carry;
  logic               r_c_msb_in;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_sum;
  logic               w_cout;
  logic               w_is_sub;

  assign w_is_sub = (sub == OP_SUB);

  adder u_bit_adder (
    .a        (r_a[0]),
    .b        (r_b[0]),
    .CarryIn  (r_carry),
    .Sum      (w_sum),
    .CarryOut (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sh       <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_a     <= a_in;
            r_b     <= b_in ^ {WIDTH{w_is_sub}};
            r_carry <= w_is_sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_sh    <= {w_sum, r_sh[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_c_msb_in <= r_carry;
              busy       <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          result    <= r_sh;
          carry_out <= r_carry;
          overflow  <= r_c_msb_in ^ r_carry;
          zero      <= (r_sh == '0);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_add_sequencer : directed checks on an 8-bit and a 32-bit instance
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        busy, done, carry_out, overflow, zero;
  logic [7:0]  result;

  logic        start32 = 1'b0;
  logic        sub32 = 1'b0;
  logic        abort32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        busy32, done32, carry_out32, overflow32, zero32;
  logic [31:0] result32;

  int n_cmp = 0;
  int n_err = 0;
  int nd;
  int lat;
  logic [7:0] cap;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .abort(abort),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  serial_add_sequencer #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .abort(abort32),
    .a_in(a32), .b_in(b32), .busy(busy32), .done(done32), .result(result32),
    .carry_out(carry_out32), .overflow(overflow32), .zero(zero32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one op, then follow it until done (bounded), counting latency and busy cycles.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int n_lat, output int n_busy);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    tick;
    start  = 1'b0;
    n_lat  = 0;
    n_busy = 0;
    while (!done && n_lat < 20) begin
      if (busy) n_busy++;
      tick;
      n_lat++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] r, input logic co,
                        input logic ov, input logic z);
    int l, nb;
    run_op(a, b, s, l, nb);
    chk({tag, ".lat"},  l, 9);
    chk({tag, ".busy"}, nb, 8);
    chk({tag, ".res"},  result, r);
    chk({tag, ".co"},   carry_out, co);
    chk({tag, ".ov"},   overflow, ov);
    chk({tag, ".zero"}, zero, z);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result", result, 8'h00);
    chk("rst.zero",   zero, 1'b1);
    chk("rst.done",   done, 1'b0);
    chk("rst.busy",   busy, 1'b0);
    #3 rst_n = 1'b1;
    nd = 0;
    repeat (4) begin
      tick;
      if (done) nd++;
    end
    chk("rst.nodone", nd, 0);

    op_chk("add1", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    op_chk("add2", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op_chk("add3", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op_chk("sub1", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    op_chk("sub2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    op_chk("sub0", 8'h55, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);

    // start pulsed in RUN and in the DONE cycle must be ignored
    a_in = 8'h12; b_in = 8'h34; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0;
    cap = '0;
    for (int n = 0; n < 25; n++) begin
      if (done) begin
        nd++;
        cap = result;
      end
      if (n == 3 || n == 8) begin
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    chk("ign.ndone", nd, 1);
    chk("ign.res",   cap, 8'h46);

    // second start issued in the done cycle lands on the earliest legal edge
    op_chk("b2b1", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    op_chk("b2b2", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);

    a_in = 8'h10; b_in = 8'h20; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort.busy", busy, 1'b0);
    nd = 0;
    repeat (15) begin
      if (done) nd++;
      tick;
    end
    chk("abort.ndone", nd, 0);
    chk("abort.res",   result, 8'h41);
    chk("abort.zero",  zero, 1'b0);

    a_in = 8'hFF; b_in = 8'hFF; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    #3 rst_n = 1'b0;
    #1;
    chk("arst.busy",   busy, 1'b0);
    chk("arst.done",   done, 1'b0);
    chk("arst.result", result, 8'h00);
    chk("arst.zero",   zero, 1'b1);
    chk("arst.co",     carry_out, 1'b0);
    chk("arst.ov",     overflow, 1'b0);
    #3 rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      tick;
      if (done) nd++;
    end
    chk("arst.ndone", nd, 0);

    a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; start32 = 1'b1;
    tick;
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 50) begin
      tick;
      lat++;
    end
    chk("w32.lat", lat, 33);
    chk("w32.res", result32, 32'h8000_0000);
    chk("w32.ov",  overflow32, 1'b1);
    chk("w32.co",  carry_out32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
